// File: rtl/fetch_decode_ctrl_if.sv
// fetch_decode_ctrl_if
//   Bundles the signals between the fetch/decode controller, the external
//   instruction ROM and the register-file/ALU datapath.
//
//   master modport (controller side):
//     inputs : instr[15:0], stall, Zero
//     outputs: PC[PC_WIDTH-1:0], RA1/RA2/WA[3:0], immediate[7:0],
//              ALUControl[1:0], ALUSrc, write_enable, halted, retired[15:0]
//   slave modport (ROM/datapath side): same signals, opposite directions.
interface fetch_decode_ctrl_if #(
    parameter int PC_WIDTH = 8
);
    logic [15:0]         instr;
    logic                stall;
    logic                Zero;
    logic [PC_WIDTH-1:0] PC;
    logic [3:0]          RA1;
    logic [3:0]          RA2;
    logic [3:0]          WA;
    logic [7:0]          immediate;
    logic [1:0]          ALUControl;
    logic                ALUSrc;
    logic                write_enable;
    logic                halted;
    logic [15:0]         retired;

    modport master (
        input  instr, stall, Zero,
        output PC, RA1, RA2, WA, immediate, ALUControl, ALUSrc,
               write_enable, halted, retired
    );

    modport slave (
        output instr, stall, Zero,
        input  PC, RA1, RA2, WA, immediate, ALUControl, ALUSrc,
               write_enable, halted, retired
    );
endinterface

// File: rtl/fetch_decode_ctrl.sv
// fetch_decode_ctrl
//   Two-cycle (FETCH, EXEC) sequencer in front of the register-file/ALU
//   datapath. Fetches a 16-bit word from a combinational ROM at PC, latches
//   it in IR, drives decoded datapath controls during EXEC, advances PC and
//   counts retired instructions (saturating). HALT opcode parks the block
//   until RESET.
//
//   Ports:
//     CLK    - clock, all state on the rising edge
//     RESET  - synchronous active-high reset
//     bus    - fetch_decode_ctrl_if.master (instr/stall/Zero in, PC,
//              register addresses, immediate, ALU controls, write_enable,
//              halted, retired out)
//
//   Build option: define FETCH_DECODE_BRANCH_EN to enable opcode 8 (BEQZ).
//   Without it opcode 8 is a NOP and Zero is ignored.
module fetch_decode_ctrl #(
    parameter int PC_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    fetch_decode_ctrl_if.master   bus
);

    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_ADDI = 4'd5;
    localparam logic [3:0] OP_SUBI = 4'd6;
    localparam logic [3:0] OP_BEQZ = 4'd8;
    localparam logic [3:0] OP_HALT = 4'd15;

    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] ra1;
        logic [3:0] ra2;
        logic [3:0] wa;
        logic [7:0] imm;
        logic [1:0] alu;
        logic       src;
        logic       we;
    } dec_t;

    state_t              state;
    logic [15:0]         ir;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] next_pc;
    logic [15:0]         retired;
    logic                halted;
    dec_t                dec_q;

    // Retired counter sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // PC + 1 + sign-extended 8-bit offset, modulo 2^PC_WIDTH.
    function automatic logic [PC_WIDTH-1:0] branch_target(
        input logic [PC_WIDTH-1:0] pc_v,
        input logic [7:0]          off
    );
        logic signed [31:0] off_s;
        logic [31:0]        sum;
        off_s = 32'(signed'(off));
        sum   = 32'(pc_v) + 32'd1 + off_s;
        return sum[PC_WIDTH-1:0];
    endfunction

    // Datapath controls for one instruction word; unknown opcodes give all zeros.
    function automatic dec_t decode(input logic [15:0] w);
        dec_t       d;
        logic [3:0] alu_full;
        d        = '0;
        alu_full = w[15:12] - 4'd1;
        case (w[15:12])
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                d.wa  = w[11:8];
                d.ra1 = w[7:4];
                d.ra2 = w[3:0];
                d.alu = alu_full[1:0];
                d.we  = 1'b1;
            end
            OP_ADDI, OP_SUBI: begin
                d.wa  = w[11:8];
                d.ra1 = w[11:8];
                d.imm = w[7:0];
                d.src = 1'b1;
                d.alu = (w[15:12] == OP_SUBI) ? 2'b01 : 2'b00;
                d.we  = 1'b1;
            end
`ifdef FETCH_DECODE_BRANCH_EN
            OP_BEQZ: begin
                // Compare register d against zero via OR with immediate 0.
                d.ra1 = w[11:8];
                d.src = 1'b1;
                d.alu = 2'b11;
            end
`endif
            default: d = '0;
        endcase
        return d;
    endfunction

`ifdef FETCH_DECODE_BRANCH_EN
    always_comb begin
        next_pc = pc + PC_ONE;
        if (ir[15:12] == OP_BEQZ && bus.Zero)
            next_pc = branch_target(pc, ir[7:0]);
    end

    logic unused_ir;
    assign unused_ir = ^ir[11:8];
`else
    always_comb begin
        next_pc = pc + PC_ONE;
    end

    logic unused_ir;
    assign unused_ir = ^{ir[11:0], bus.Zero};
`endif

    // Decode is registered on the FETCH->EXEC edge so outputs are glitch-free
    // in EXEC and forced back to zero on the edge that leaves EXEC.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= ST_FETCH;
            pc      <= '0;
            ir      <= '0;
            retired <= '0;
            halted  <= 1'b0;
            dec_q   <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (!bus.stall) begin
                        ir    <= bus.instr;
                        dec_q <= decode(bus.instr);
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    dec_q   <= '0;
                    retired <= sat_inc16(retired);
                    if (ir[15:12] == OP_HALT) begin
                        halted <= 1'b1;
                        state  <= ST_HALT;
                    end else begin
                        pc    <= next_pc;
                        state <= ST_FETCH;
                    end
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_FETCH;
            endcase
        end
    end

    assign bus.PC           = pc;
    assign bus.RA1          = dec_q.ra1;
    assign bus.RA2          = dec_q.ra2;
    assign bus.WA           = dec_q.wa;
    assign bus.immediate    = dec_q.imm;
    assign bus.ALUControl   = dec_q.alu;
    assign bus.ALUSrc       = dec_q.src;
    // A write must never land in a cycle where RESET is high.
    assign bus.write_enable = dec_q.we & ~RESET;
    assign bus.halted       = halted;
    assign bus.retired      = retired;

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
module tb_fetch_decode_ctrl;

    localparam int PCW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] rom [0:255];

    fetch_decode_ctrl_if #(.PC_WIDTH(PCW)) bus();
    assign bus.instr = rom[bus.PC];

    fetch_decode_ctrl #(.PC_WIDTH(PCW)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [3:0] ra1;
        logic [3:0] ra2;
        logic [3:0] wa;
        logic [7:0] imm;
        logic [1:0] alu;
        logic       src;
        logic       we;
    } dec_t;

    // Reference decode straight from the opcode table.
    function automatic dec_t model_dec(input logic [15:0] w);
        dec_t r;
        int   op;
        r  = '0;
        op = int'(w[15:12]);
        if (op >= 1 && op <= 4) begin
            r.wa = w[11:8]; r.ra1 = w[7:4]; r.ra2 = w[3:0];
            r.alu = 2'(op - 1); r.we = 1'b1;
        end else if (op == 5 || op == 6) begin
            r.wa = w[11:8]; r.ra1 = w[11:8]; r.imm = w[7:0];
            r.src = 1'b1; r.alu = 2'(op - 5); r.we = 1'b1;
        end
`ifdef FETCH_DECODE_BRANCH_EN
        else if (op == 8) begin
            r.ra1 = w[11:8]; r.src = 1'b1; r.alu = 2'b11;
        end
`endif
        return r;
    endfunction

    function automatic int model_next_pc(input int pc, input logic [15:0] w, input logic z);
        int n;
        n = pc + 1;
`ifdef FETCH_DECODE_BRANCH_EN
        if (w[15:12] == 4'd8 && z) n = n + int'($signed(w[7:0]));
`endif
        return n & ((1 << PCW) - 1);
    endfunction

    function automatic dec_t obs_dec();
        dec_t r;
        r.ra1 = bus.RA1; r.ra2 = bus.RA2; r.wa = bus.WA; r.imm = bus.immediate;
        r.alu = bus.ALUControl; r.src = bus.ALUSrc; r.we = bus.write_enable;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.stall = 1'b0; bus.Zero = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    endtask

    task automatic test_reset();
        clear_rom();
        rst = 1'b1; bus.stall = 1'b1; bus.Zero = 1'b1;
        tick(); tick();
        vectors++;
        if (bus.PC !== '0) begin miscompares++; $display("FAIL reset_pc: got %0d want 0", bus.PC); end
        vectors++;
        if (bus.halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted: got %b want 0", bus.halted); end
        vectors++;
        if (bus.retired !== 16'd0) begin miscompares++; $display("FAIL reset_retired: got %0d want 0", bus.retired); end
        vectors++;
        if (obs_dec() !== dec_t'('0)) begin miscompares++; $display("FAIL reset_dec: got %h want 0", obs_dec()); end
        rst = 1'b0; bus.stall = 1'b0; bus.Zero = 1'b0;
    endtask

    task automatic test_addi_add();
        clear_rom();
        rom[0] = 16'h5105;
        rom[1] = 16'h1312;
        do_reset();
        vectors++;
        if (obs_dec() !== dec_t'('0) || bus.PC !== 8'd0) begin
            miscompares++; $display("FAIL addi_fetch: dec %h pc %0d want 0/0", obs_dec(), bus.PC);
        end
        tick();
        vectors++;
        if ({bus.WA, bus.RA1, bus.immediate, bus.ALUSrc, bus.ALUControl, bus.write_enable}
            !== {4'd1, 4'd1, 8'd5, 1'b1, 2'b00, 1'b1}) begin
            miscompares++; $display("FAIL addi_exec: got %h want %h", obs_dec(), model_dec(16'h5105));
        end
        tick();
        vectors++;
        if (bus.PC !== 8'd1 || bus.retired !== 16'd1) begin
            miscompares++; $display("FAIL addi_retire: pc %0d ret %0d want 1/1", bus.PC, bus.retired);
        end
        tick();
        vectors++;
        if ({bus.WA, bus.RA1, bus.RA2, bus.ALUSrc, bus.ALUControl, bus.write_enable}
            !== {4'd3, 4'd1, 4'd2, 1'b0, 2'b00, 1'b1}) begin
            miscompares++; $display("FAIL add_exec: got %h want %h", obs_dec(), model_dec(16'h1312));
        end
        tick();
        vectors++;
        if (bus.PC !== 8'd2 || bus.retired !== 16'd2 || obs_dec() !== dec_t'('0)) begin
            miscompares++; $display("FAIL add_retire: pc %0d ret %0d dec %h want 2/2/0", bus.PC, bus.retired, obs_dec());
        end
    endtask

    task automatic test_branch();
        logic z;
        int   want;
        for (int k = 0; k < 2; k++) begin
            z = (k == 0);
            clear_rom();
            rom[10] = 16'h84FD;
            do_reset();
            for (int i = 0; i < 20; i++) tick();
            vectors++;
            if (bus.PC !== 8'd10) begin miscompares++; $display("FAIL branch_setup: pc %0d want 10", bus.PC); end
            tick();
            vectors++;
            if (obs_dec() !== model_dec(16'h84FD) || bus.write_enable !== 1'b0) begin
                miscompares++; $display("FAIL branch_exec: got %h want %h", obs_dec(), model_dec(16'h84FD));
            end
            bus.Zero = z;
            tick();
`ifdef FETCH_DECODE_BRANCH_EN
            want = z ? 8 : 11;
`else
            want = 11;
`endif
            vectors++;
            if (bus.PC !== PCW'(want)) begin
                miscompares++; $display("FAIL branch_pc zero=%b: got %0d want %0d", z, bus.PC, want);
            end
            bus.Zero = 1'b0;
        end
    endtask

    task automatic test_stall();
        clear_rom();
        rom[0] = 16'h5105;
        do_reset();
        bus.stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) rom[0] = 16'h1312;
            tick();
            vectors++;
            if (bus.PC !== 8'd0 || bus.retired !== 16'd0 || obs_dec() !== dec_t'('0)) begin
                miscompares++; $display("FAIL stall_hold %0d: pc %0d ret %0d dec %h want 0/0/0", i, bus.PC, bus.retired, obs_dec());
            end
        end
        bus.stall = 1'b0;
        tick();
        vectors++;
        if (obs_dec() !== model_dec(16'h1312)) begin
            miscompares++; $display("FAIL stall_resume: got %h want %h", obs_dec(), model_dec(16'h1312));
        end
        bus.stall = 1'b1;
        tick();
        vectors++;
        if (bus.PC !== 8'd1 || bus.retired !== 16'd1) begin
            miscompares++; $display("FAIL stall_in_exec: pc %0d ret %0d want 1/1", bus.PC, bus.retired);
        end
        bus.stall = 1'b0;
    endtask

    task automatic test_halt();
        clear_rom();
        rom[3] = 16'hF000;
        do_reset();
        for (int i = 0; i < 6; i++) tick();
        tick();
        vectors++;
        if (bus.PC !== 8'd3 || bus.halted !== 1'b0) begin
            miscompares++; $display("FAIL halt_exec: pc %0d halted %b want 3/0", bus.PC, bus.halted);
        end
        tick();
        vectors++;
        if (bus.halted !== 1'b1 || bus.PC !== 8'd3 || bus.retired !== 16'd4) begin
            miscompares++; $display("FAIL halt_enter: halted %b pc %0d ret %0d want 1/3/4", bus.halted, bus.PC, bus.retired);
        end
        for (int i = 0; i < 5; i++) begin
            bus.stall = 1'($urandom);
            tick();
            vectors++;
            if (bus.halted !== 1'b1 || bus.PC !== 8'd3 || bus.retired !== 16'd4 || obs_dec() !== dec_t'('0)) begin
                miscompares++; $display("FAIL halt_hold %0d: halted %b pc %0d ret %0d want 1/3/4", i, bus.halted, bus.PC, bus.retired);
            end
        end
        bus.stall = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (bus.halted !== 1'b0 || bus.PC !== 8'd0 || bus.retired !== 16'd0) begin
            miscompares++; $display("FAIL halt_reset: halted %b pc %0d ret %0d want 0/0/0", bus.halted, bus.PC, bus.retired);
        end
    endtask

    task automatic test_reset_in_exec();
        clear_rom();
        rom[0] = 16'h1312;
        do_reset();
        tick();
        vectors++;
        if (bus.write_enable !== 1'b1) begin miscompares++; $display("FAIL rexec_we_before: got %b want 1", bus.write_enable); end
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.write_enable !== 1'b0) begin miscompares++; $display("FAIL rexec_we_gated: got %b want 0", bus.write_enable); end
        tick();
        vectors++;
        if (bus.PC !== 8'd0 || bus.retired !== 16'd0 || obs_dec() !== dec_t'('0)) begin
            miscompares++; $display("FAIL rexec_state: pc %0d ret %0d dec %h want 0/0/0", bus.PC, bus.retired, obs_dec());
        end
        rst = 1'b0;
        tick();
        vectors++;
        if (obs_dec() !== model_dec(16'h1312)) begin
            miscompares++; $display("FAIL rexec_refetch: got %h want %h", obs_dec(), model_dec(16'h1312));
        end
    endtask

    task automatic test_pc_wrap();
        clear_rom();
        do_reset();
        for (int i = 0; i < 510; i++) tick();
        vectors++;
        if (bus.PC !== 8'd255) begin miscompares++; $display("FAIL wrap_setup: pc %0d want 255", bus.PC); end
        tick(); tick();
        vectors++;
        if (bus.PC !== 8'd0 || bus.retired !== 16'd256) begin
            miscompares++; $display("FAIL wrap_pc: pc %0d ret %0d want 0/256", bus.PC, bus.retired);
        end
    endtask

    task automatic test_random();
        int          mpc;
        int          mret;
        int          nst;
        logic [15:0] w;
        logic        z;
        for (int i = 0; i < 256; i++) rom[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
        do_reset();
        mpc  = 0;
        mret = 0;
        for (int n = 0; n < 300; n++) begin
            nst = $urandom_range(0, 2);
            for (int s = 0; s < nst; s++) begin
                bus.stall = 1'b1; bus.Zero = 1'($urandom);
                tick();
                vectors++;
                if (bus.PC !== PCW'(mpc) || bus.retired !== 16'(mret) || obs_dec() !== dec_t'('0)) begin
                    miscompares++; $display("FAIL rand_stall %0d: pc %0d ret %0d dec %h want %0d/%0d/0", n, bus.PC, bus.retired, obs_dec(), mpc, mret);
                end
            end
            w = rom[mpc];
            bus.stall = 1'b0;
            tick();
            vectors++;
            if (obs_dec() !== model_dec(w) || bus.halted !== 1'b0) begin
                miscompares++; $display("FAIL rand_exec %0d instr %h: got %h want %h", n, w, obs_dec(), model_dec(w));
            end
            z = 1'($urandom);
            bus.Zero  = z;
            bus.stall = 1'($urandom);
            tick();
            mpc  = model_next_pc(mpc, w, z);
            mret = (mret < 65535) ? mret + 1 : mret;
            vectors++;
            if (bus.PC !== PCW'(mpc) || bus.retired !== 16'(mret)) begin
                miscompares++; $display("FAIL rand_retire %0d instr %h: pc %0d ret %0d want %0d/%0d", n, w, bus.PC, bus.retired, mpc, mret);
            end
        end
        bus.stall = 1'b0;
        bus.Zero  = 1'b0;
    endtask

    initial begin
        bus.stall = 1'b0;
        bus.Zero  = 1'b0;
        clear_rom();
        test_reset();
        test_addi_add();
        test_branch();
        test_stall();
        test_halt();
        test_reset_in_exec();
        test_pc_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
